data_fifo_frame: RTL and testbench
==================================

DATA_FIFO_FRAME -- requirements
Module: data_fifo_frame

Interface
REQ-001 Parameter DATA_W, default 32: bit width of one lane word.
REQ-002 Parameter FRAME_LEN, default 16: words per frame per lane; power of two, 4..1024.
REQ-003 Parameter LANES, default 1: parallel lanes sharing one control path; 1..4.
REQ-004 Parameter MODE, default 0: 0 = in-order frame delay, 1 = bit-reversed address readout.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 data_in  input  DATA_W*LANES  lane k at bits [k*DATA_W +: DATA_W], sampled every cycle.
REQ-008 ctrl_in  input  1  high on the cycle carrying word 0 of a new frame.
REQ-009 data_out  output  DATA_W*LANES  reordered/delayed frame words, same lane packing.
REQ-010 ctrl_out  output  1  high on the cycle data_out carries output word 0.
REQ-011 valid_out  output  1  high while data_out carries frame words.
REQ-012 err_out  output  1  one-cycle pulse on frame truncation.

Function
REQ-013 The block SHALL hold two banks (ping-pong), each FRAME_LEN words x LANES.
REQ-014 Write side states: IDLE, FILL; ctrl_in in any state SHALL write data_in at wr_cnt=0 of the current write bank and enter FILL.
REQ-015 In FILL, each cycle SHALL write data_in at wr_cnt and increment wr_cnt; input is ignored in IDLE.
REQ-016 Write at wr_cnt=FRAME_LEN-1 SHALL complete the frame: toggle write bank, mark bank full, return to IDLE unless ctrl_in arrives next cycle.
REQ-017 ctrl_in while in FILL with wr_cnt != 0 SHALL discard the partial frame (no bank toggle, no output), restart at wr_cnt=0 same bank, and pulse err_out the following cycle.
REQ-018 Read side SHALL start the cycle after a bank completes, reading rd_cnt 0..FRAME_LEN-1 one per cycle.
REQ-019 Read address SHALL be rd_cnt in MODE 0 and bit-reverse of rd_cnt over log2(FRAME_LEN) bits in MODE 1.
REQ-020 Memory read SHALL be registered: data_out SHALL appear one cycle after its address.
REQ-021 Latency: input word 0 at cycle T SHALL produce ctrl_out and output word 0 at cycle T+FRAME_LEN+1.
REQ-022 valid_out SHALL be high exactly FRAME_LEN consecutive cycles per completed frame; ctrl_out only on the first.
REQ-023 Back-to-back frames (ctrl_in at T+FRAME_LEN) SHALL stream gap-free with valid_out continuously high.
REQ-024 Reading a bank SHALL never overlap writing the same bank; equal rates guarantee this, no backpressure exists.
REQ-025 When valid_out is low, data_out SHALL hold its last value.
REQ-026 All lanes SHALL use identical addresses and timing.

Reset
REQ-027 rst SHALL asynchronously force: data_out=0, ctrl_out=0, valid_out=0, err_out=0, wr_cnt=0, rd_cnt=0, write bank=0, both banks empty, write state IDLE, read idle.
REQ-028 Memory contents need not be cleared; no stale word SHALL ever reach data_out with valid_out high.
REQ-029 rst mid-frame SHALL abandon both in-progress write and read; first post-reset output requires a fresh complete frame.

Structure
REQ-030 Shared package fft_fifo_pkg SHALL hold MODE_DELAY=0 / MODE_BITREV=1 constants and the clog2 and bit-reverse functions.
REQ-031 One sub-module frame_ram (simple dual-port, registered read, depth 2*FRAME_LEN, width DATA_W*LANES) SHALL hold both banks, bank as address MSB.
REQ-032 Control (write FSM, read counter, bank flags) SHALL live in data_fifo_frame.

Verification (DATA_W=32, FRAME_LEN=16, LANES=1 unless stated)
REQ-033 MODE 0, ctrl_in with word 0, words 0..15 -> ctrl_out 17 cycles after ctrl_in, data_out 0..15, valid_out high 16 cycles.
REQ-034 MODE 1, words 0..15 -> data_out 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
REQ-035 Two frames back-to-back, words 1..16 then 17..32 -> 32 contiguous valid cycles, ctrl_out on outputs 1 and 17.
REQ-036 ctrl_in at word 9, then full frame 100..115 -> err_out pulses once, only 100..115 emerge.
REQ-037 rst asserted asynchronously at word 8 of a frame, then full frame -> all outputs 0 immediately, only the new frame emerges.
REQ-038 LANES=4, lane k word n = 16k+n -> each lane delivers its own sequence, lanes aligned in the same cycle.

Source files
------------

// File: rtl/fft_fifo_pkg.sv
// Shared constants and helpers for the frame FIFO: readout modes, write FSM
// states, a constant-foldable clog2 and a variable-width bit reversal.
package fft_fifo_pkg;

  localparam int MODE_DELAY  = 0;
  localparam int MODE_BITREV = 1;

  // Widest frame address supported (FRAME_LEN up to 1024).
  localparam int MAX_AW = 10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_FILL = 1'b1
  } wr_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low 'width' bits of value; upper bits of the result are zero.
  function automatic logic [MAX_AW-1:0] bit_rev(input logic [MAX_AW-1:0] value,
                                                input int width);
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_AW; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port RAM holding both ping-pong banks, one write port and one
// registered read port whose output register holds when no read is issued.
module frame_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output
  // register is reset, and the bank flags stop stale words from being read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/data_fifo_frame.sv
// Ping-pong frame buffer: fills one bank while the other is read out either
// in order or in bit-reversed order, with frame truncation detection.
module data_fifo_frame
  import fft_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 16,
  parameter int LANES     = 1,
  parameter int MODE      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W*LANES-1:0] data_in,
  input  logic                    ctrl_in,
  output logic [DATA_W*LANES-1:0] data_out,
  output logic                    ctrl_out,
  output logic                    valid_out,
  output logic                    err_out
);

  localparam int              AW   = clog2(FRAME_LEN);
  localparam int              W    = DATA_W * LANES;
  localparam logic [AW-1:0]   LAST = AW'(FRAME_LEN - 1);

  wr_state_t     state, state_nxt;
  logic [AW-1:0] wr_cnt, wr_cnt_nxt, wr_addr_lo;
  logic          wr_bank, wr_en, frame_done, trunc;

  logic [1:0]    full, full_set, full_clr;
  logic [AW-1:0] rd_cnt, rd_addr_lo;
  logic          rd_bank, rd_en, rd_last;

  // Write side: ctrl_in always restarts at word 0 of the current bank.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the branches below can infer a latch.
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    wr_addr_lo = wr_cnt;
    wr_en      = 1'b0;
    frame_done = 1'b0;
    trunc      = 1'b0;
    if (ctrl_in) begin
      wr_en      = 1'b1;
      wr_addr_lo = '0;
      wr_cnt_nxt = AW'(1);
      state_nxt  = WR_FILL;
      trunc      = (state == WR_FILL);
    end else if (state == WR_FILL) begin
      wr_en = 1'b1;
      if (wr_cnt == LAST) begin
        frame_done = 1'b1;
        wr_cnt_nxt = '0;
        state_nxt  = WR_IDLE;
      end else begin
        wr_cnt_nxt = wr_cnt + AW'(1);
      end
    end
  end

  // Read side runs whenever the bank it points at is full; banks are
  // consumed in the same order they are filled.
  assign rd_en   = full[rd_bank];
  assign rd_last = rd_en && (rd_cnt == LAST);

  assign full_set = frame_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = rd_last    ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  assign rd_addr_lo = (MODE == MODE_BITREV) ? AW'(bit_rev(MAX_AW'(rd_cnt), AW))
                                            : rd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WR_IDLE;
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      full      <= 2'b00;
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      valid_out <= 1'b0;
      ctrl_out  <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      err_out   <= trunc;
      full      <= (full & ~full_clr) | full_set;
      valid_out <= rd_en;
      ctrl_out  <= rd_en && (rd_cnt == '0);
      if (frame_done) wr_bank <= ~wr_bank;
      if (rd_last) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + AW'(1);
      end
    end
  end

  frame_ram #(
    .WIDTH (W),
    .DEPTH (2 * FRAME_LEN),
    .AW    (AW + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_addr_lo}),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr_lo}),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_data_fifo_frame.sv
// Bench for data_fifo_frame: in-order, bit-reversed and 4-lane instances
// driven together and compared every cycle against a frame-level scoreboard.
module tb_data_fifo_frame;

  localparam int LEN  = 16;
  localparam int LOG2 = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctrl_in;
  logic [31:0]  din;
  logic [127:0] din4;

  logic [31:0]  dout0, dout1;
  logic [127:0] dout4;
  logic         ctrl0, valid0, err0;
  logic         ctrl1, valid1, err1;
  logic         ctrl4, valid4, err4;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int cnt_valid, cnt_ctrl, cnt_err;

  always #5 clk = ~clk;

  data_fifo_frame #(.DATA_W(32), .FRAME_LEN(LEN), .LANES(1), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(din), .ctrl_in(ctrl_in),
    .data_out(dout0), .ctrl_out(ctrl0), .valid_out(valid0), .err_out(err0));

  data_fifo_frame #(.DATA_W(32), .FRAME_LEN(LEN), .LANES(1), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(din), .ctrl_in(ctrl_in),
    .data_out(dout1), .ctrl_out(ctrl1), .valid_out(valid1), .err_out(err1));

  data_fifo_frame #(.DATA_W(32), .FRAME_LEN(LEN), .LANES(4), .MODE(0)) dut4 (
    .clk(clk), .rst(rst), .data_in(din4), .ctrl_in(ctrl_in),
    .data_out(dout4), .ctrl_out(ctrl4), .valid_out(valid4), .err_out(err4));

  // Scoreboard: expected outputs keyed by the cycle they must appear in.
  logic [31:0]  part[$];
  bit           collecting;
  logic [31:0]  exp0[int];
  logic [31:0]  exp1[int];
  bit           exp_first[int];
  bit           exp_err[int];
  logic [31:0]  last0, last1;
  logic [127:0] last4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  function automatic int rev(input int i);
    int r = 0;
    int v = i;
    for (int b = 0; b < LOG2; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [127:0] lanes(input logic [31:0] x);
    return {x + 32'd48, x + 32'd32, x + 32'd16, x};
  endfunction

  task automatic model_reset();
    part.delete();
    collecting = 1'b0;
    exp0.delete();
    exp1.delete();
    exp_first.delete();
    exp_err.delete();
    last0 = '0;
    last1 = '0;
    last4 = '0;
  endtask

  // Word 0 in cycle t emerges in cycle t+LEN+1, i.e. two cycles after the last word.
  task automatic model_input(input bit c, input logic [31:0] d);
    if (c) begin
      if (part.size() > 0) exp_err[cyc + 1] = 1'b1;
      part.delete();
      part.push_back(d);
      collecting = 1'b1;
    end else if (collecting) begin
      part.push_back(d);
    end
    if (collecting && part.size() == LEN) begin
      for (int i = 0; i < LEN; i++) begin
        exp0[cyc + 2 + i] = part[i];
        exp1[cyc + 2 + i] = part[rev(i)];
      end
      exp_first[cyc + 2] = 1'b1;
      part.delete();
      collecting = 1'b0;
    end
  endtask

  task automatic check_model();
    bit v, f, e;
    v = exp0.exists(cyc);
    f = exp_first.exists(cyc);
    e = exp_err.exists(cyc);
    if (v) begin
      last0 = exp0[cyc];
      last1 = exp1[cyc];
      last4 = lanes(exp0[cyc]);
    end
    check("mode0", 128'({valid0, ctrl0, err0, dout0}), 128'({v, f, e, last0}));
    check("mode1", 128'({valid1, ctrl1, err1, dout1}), 128'({v, f, e, last1}));
    check("lane4_flags", 128'({valid4, ctrl4, err4}), 128'({v, f, e}));
    check("lane4_data", dout4, last4);
  endtask

  // One cycle: check outputs at the start of the cycle, then drive its inputs.
  task automatic tick(input bit c, input logic [31:0] d);
    @(negedge clk);
    cyc++;
    check_model();
    cnt_valid += int'(valid0);
    cnt_ctrl  += int'(ctrl0);
    cnt_err   += int'(err0);
    ctrl_in = c;
    din     = d;
    din4    = lanes(d);
    model_input(c, d);
  endtask

  task automatic clear_counts();
    cnt_valid = 0;
    cnt_ctrl  = 0;
    cnt_err   = 0;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vt[LEN];
  int   br[LEN] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  initial begin
    rst     = 1'b1;
    ctrl_in = 1'b0;
    din     = '0;
    din4    = '0;
    model_reset();
    clear_counts();
    for (int i = 0; i < LEN; i++) vt[i] = '{din: i, exp0: i, exp1: br[i]};

    repeat (2) @(negedge clk);
    check("reset_m0", 128'({valid0, ctrl0, err0, dout0}), 128'(0));
    check("reset_m1", 128'({valid1, ctrl1, err1, dout1}), 128'(0));
    check("reset_l4", 128'({valid4, ctrl4, err4}) | dout4, 128'(0));
    rst = 1'b0;

    // Single frame 0..15: in-order and bit-reversed readout from the table.
    tick(1'b0, 32'd77);
    for (int i = 0; i < LEN; i++) tick(i == 0, vt[i].din);
    tick(1'b0, $urandom);
    for (int j = 0; j < LEN; j++) begin
      tick(1'b0, $urandom);
      check("tbl_m0", 128'({valid0, ctrl0, dout0}), 128'({1'b1, j == 0, vt[j].exp0}));
      check("tbl_m1", 128'({valid1, ctrl1, dout1}), 128'({1'b1, j == 0, vt[j].exp1}));
    end
    tick(1'b0, $urandom);
    check("tbl_end", 128'({valid0, dout0}), 128'({1'b0, vt[LEN-1].exp0}));

    // Two frames back-to-back: 32 contiguous valid cycles, two ctrl pulses.
    repeat (3) tick(1'b0, $urandom);
    clear_counts();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < LEN; i++) tick(i == 0, 32'(1 + 16 * f + i));
    repeat (20) tick(1'b0, $urandom);
    check("b2b_valid", 128'(cnt_valid), 128'(32));
    check("b2b_ctrl", 128'(cnt_ctrl), 128'(2));

    // Truncation at word 9, then a full frame 100..115.
    clear_counts();
    for (int i = 0; i < 9; i++) tick(i == 0, 32'(i));
    for (int i = 0; i < LEN; i++) tick(i == 0, 32'(100 + i));
    repeat (20) tick(1'b0, $urandom);
    check("trunc_err", 128'(cnt_err), 128'(1));
    check("trunc_valid", 128'(cnt_valid), 128'(16));

    // Async reset while the previous frame streams out and a new one fills.
    for (int i = 0; i < LEN; i++) tick(i == 0, 32'(300 + i));
    for (int i = 0; i < 9; i++) tick(i == 0, 32'(400 + i));
    #2 rst = 1'b1;
    #1;
    check("arst_m0", 128'({valid0, ctrl0, err0, dout0}), 128'(0));
    check("arst_m1", 128'({valid1, ctrl1, err1, dout1}), 128'(0));
    check("arst_l4", 128'({valid4, ctrl4, err4}) | dout4, 128'(0));
    model_reset();
    tick(1'b0, $urandom);
    rst = 1'b0;
    clear_counts();
    repeat (20) tick(1'b0, $urandom);
    check("arst_quiet", 128'(cnt_valid), 128'(0));
    for (int i = 0; i < LEN; i++) tick(i == 0, 32'(500 + i));
    repeat (20) tick(1'b0, $urandom);
    check("arst_frame", 128'(cnt_valid), 128'(16));

    // Random frames with gaps and occasional truncation.
    for (int f = 0; f < 25; f++) begin
      int gap, n;
      gap = int'($urandom_range(0, 3));
      n   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LEN - 1)) : LEN;
      repeat (gap) tick(1'b0, $urandom);
      for (int i = 0; i < n; i++) tick(i == 0, $urandom);
    end
    repeat (LEN + 4) tick(1'b0, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
